timer_sample_scheduler: RTL and testbench
=========================================

Name: timer_sample_scheduler

Overview:
- Avalon-MM master that owns the s1 slave of the 16-bit-register interval timer and sequences it for accelerometer sampling.
- Programs the period, starts the timer in continuous mode with interrupt enabled, and services each timeout by clearing TO.
- Converts each tick into a req/ack handshake to the downstream sample reader and counts ticks missed while a request is still pending.

Parameters:
- DEFAULT_INTERVAL, 50000: interval in clocks, used when `interval` < 2.
- OVR_W, 8: width of the saturating overrun counter.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- enable  input  1  level; 1 = run periodic sampling, 0 = stop timer
- interval  input  32  tick interval in clocks; sampled only at program time
- reprogram  input  1  one-cycle pulse; reload `interval` while running
- tmr_address  output  3  timer register address
- tmr_chipselect  output  1  timer chip select
- tmr_write_n  output  1  timer write strobe, active low
- tmr_writedata  output  16  timer write data
- tmr_readdata  input  16  timer read data; registered, valid the cycle after address is presented
- tmr_irq  input  1  timer interrupt, level
- sample_req  output  1  sample request, held until ack
- sample_ack  input  1  one-cycle acknowledge from sample reader
- running  output  1  1 while the FSM is in RUN, CLR or CLR_GAP
- overrun_cnt  output  OVR_W  saturating count of missed ticks
- ack_latency  output  32  SCHED_LAT_EN only; clocks from tick to ack

Behaviour:
- Reset values: tmr_address=0, tmr_chipselect=0, tmr_write_n=1, tmr_writedata=0, sample_req=0, running=0, overrun_cnt=0, ack_latency=0, state=IDLE.
- All master outputs are registered. Each bus write is exactly one cycle: chipselect=1, write_n=0. The timer has no waitrequest. chipselect=0 in every other cycle.
- Load value P = interval-1; P = DEFAULT_INTERVAL-1 when interval < 2. P is latched when entering STOP.
- FSM states and register writes:
  - IDLE: go to STOP when enable=1.
  - STOP: write addr1 = 0x0008 (STOP).
  - PL: write addr2 = P[15:0].
  - PH: write addr3 = P[31:16].
  - CTRL: write addr1 = 0x0007 (START|CONT|ITO). Then go to RUN.
  - RUN, tmr_irq=1: go to CLR.
  - RUN, reprogram=1: go to STOP.
  - RUN, enable=0: go to HALT.
  - CLR: write addr0 = 0x0000 to clear TO. Go to CLR_GAP. If sample_req=1 this cycle, overrun_cnt++ (saturates at all-ones). Otherwise sample_req<=1.
  - CLR_GAP: idle cycle, because irq deasserts one cycle after the clear write. Go to RUN.
  - HALT: write addr1 = 0x0008. Go to IDLE.
- Priority in RUN: enable=0 > reprogram > tmr_irq. A tick that coincides with reprogram or disable is dropped and not counted.
- enable=0 during STOP/PL/PH/CTRL: finish the current write, then go to HALT. The timer is never left half-programmed.
- Handshake:
  - sample_ack clears sample_req on the next edge.
  - An ack while sample_req=0 is ignored.
  - sample_req is not cleared by HALT; an outstanding request still completes.
- overrun_cnt clears only on reset or on the IDLE->STOP transition.
- Reset mid-operation: all outputs return to reset values asynchronously. The timer resets with the same reset_n.

Optional Feature:
- Macro SCHED_LAT_EN.
- Defined: a 32-bit counter clears in CLR and increments every cycle while sample_req=1. On sample_ack, ack_latency <= counter+1.
- Undefined: ack_latency is tied to 0 and the counter is not built.
- FSM and bus traffic are identical either way.

Test Plan:
- Reset, enable=1, interval=100 -> writes in order addr1=0x0008, addr2=0x0063, addr3=0x0000, addr1=0x0007 on consecutive cycles; running=1 from the next cycle.
- interval=1 -> addr2=0xC34F, addr3=0x0000 (DEFAULT_INTERVAL-1).
- Running with interval=100 and ack 5 cycles after each req -> tick every 100 clocks, addr0 written once per tick, sample_req rises 1 cycle after tmr_irq is sampled, overrun_cnt=0.
- Never ack, 300 ticks, OVR_W=8 -> one req held high, overrun_cnt saturates at 255.
- enable falls during PL -> PH and CTRL are skipped, then one addr1=0x0008 write, then IDLE; irq never asserts afterwards.
- SCHED_LAT_EN defined, ack 7 cycles after req rises -> ack_latency=7. Undefined -> ack_latency=0.

Source files
------------

// File: rtl/timer_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_sample_scheduler
//  Description : Avalon-MM master that owns the s1 slave of a 16-bit-register
//                interval timer. It programs the period, starts the timer in
//                continuous mode with the interrupt enabled, clears TO on each
//                timeout, and turns every tick into a req/ack handshake
//                towards the sample reader. Ticks that arrive while a request
//                is still pending are counted in a saturating overrun counter.
//  Optional    : `define SCHED_LAT_EN builds the tick-to-ack latency counter
//                and drives ack_latency; otherwise ack_latency is tied to 0.
//  Ports       :
//    clk, reset_n         system clock, asynchronous active-low reset
//    enable               level, 1 = run periodic sampling, 0 = stop timer
//    interval[31:0]       tick interval in clocks (sampled at program time)
//    reprogram            one-cycle pulse, reload interval while running
//    tmr_address[2:0]     timer register address        (registered)
//    tmr_chipselect       timer chip select              (registered)
//    tmr_write_n          timer write strobe, active low (registered)
//    tmr_writedata[15:0]  timer write data               (registered)
//    tmr_readdata[15:0]   timer read data (never read by this master)
//    tmr_irq              timer interrupt, level
//    sample_req           sample request, held until sample_ack
//    sample_ack           one-cycle acknowledge from the sample reader
//    running              1 while in RUN, CLR or CLR_GAP
//    overrun_cnt[OVR_W]   saturating count of missed ticks
//    ack_latency[31:0]    clocks from tick to ack (SCHED_LAT_EN only)
//  Revision    : 1.0  initial release
// ============================================================================
module timer_sample_scheduler #(
    parameter int unsigned DEFAULT_INTERVAL = 50000,
    parameter int unsigned OVR_W            = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [31:0]      interval,
    input  logic             reprogram,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic [15:0]      tmr_readdata,
    input  logic             tmr_irq,
    output logic             sample_req,
    input  logic             sample_ack,
    output logic             running,
    output logic [OVR_W-1:0] overrun_cnt,
    output logic [31:0]      ack_latency
);

    localparam logic [2:0]  C_ADDR_STATUS  = 3'd0;
    localparam logic [2:0]  C_ADDR_CONTROL = 3'd1;
    localparam logic [2:0]  C_ADDR_PERIODL = 3'd2;
    localparam logic [2:0]  C_ADDR_PERIODH = 3'd3;
    localparam logic [15:0] C_CTRL_STOP    = 16'h0008;
    localparam logic [15:0] C_CTRL_START   = 16'h0007;  // START|CONT|ITO
    localparam logic [31:0] C_DEFAULT_LOAD = 32'(DEFAULT_INTERVAL - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_STOP    = 4'd1,
        S_PL      = 4'd2,
        S_PH      = 4'd3,
        S_CTRL    = 4'd4,
        S_RUN     = 4'd5,
        S_CLR     = 4'd6,
        S_CLR_GAP = 4'd7,
        S_HALT    = 4'd8
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_load;
    logic [31:0]       w_load;
    logic [2:0]        r_addr,  w_addr;
    logic              r_cs,    w_cs;
    logic [15:0]       r_wdata, w_wdata;
    logic              r_running;
    logic              r_req;
    logic [OVR_W-1:0]  r_ovr;
    logic              w_unused;

    // The master only writes; read data is deliberately ignored.
    assign w_unused = ^tmr_readdata;

    // Intervals below 2 would give a zero/negative period: fall back to default.
    assign w_load = (interval < 32'd2) ? C_DEFAULT_LOAD : (interval - 32'd1);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and next bus cycle. The bus outputs are registered from the
    // next state so each write appears exactly during its own state.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next  = r_state;
        w_cs    = 1'b0;
        w_addr  = 3'd0;
        w_wdata = 16'h0000;

        case (r_state)
            S_IDLE:    if (enable) w_next = S_STOP;
            // Programming writes always complete; a disable only redirects
            // the sequence to HALT after the write in progress.
            S_STOP:    w_next = enable ? S_PL   : S_HALT;
            S_PL:      w_next = enable ? S_PH   : S_HALT;
            S_PH:      w_next = enable ? S_CTRL : S_HALT;
            S_CTRL:    w_next = enable ? S_RUN  : S_HALT;
            S_RUN: begin
                // A tick coinciding with disable or reprogram is dropped.
                if (!enable)        w_next = S_HALT;
                else if (reprogram) w_next = S_STOP;
                else if (tmr_irq)   w_next = S_CLR;
            end
            // irq falls one cycle after the clear write; the gap cycle keeps
            // RUN from seeing the stale level as a second tick.
            S_CLR:     w_next = S_CLR_GAP;
            S_CLR_GAP: w_next = S_RUN;
            S_HALT:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase

        case (w_next)
            S_STOP, S_HALT: begin
                w_cs    = 1'b1;
                w_addr  = C_ADDR_CONTROL;
                w_wdata = C_CTRL_STOP;
            end
            S_PL: begin
                w_cs    = 1'b1;
                w_addr  = C_ADDR_PERIODL;
                w_wdata = r_load[15:0];
            end
            S_PH: begin
                w_cs    = 1'b1;
                w_addr  = C_ADDR_PERIODH;
                w_wdata = r_load[31:16];
            end
            S_CTRL: begin
                w_cs    = 1'b1;
                w_addr  = C_ADDR_CONTROL;
                w_wdata = C_CTRL_START;
            end
            S_CLR: begin
                w_cs    = 1'b1;
                w_addr  = C_ADDR_STATUS;
                w_wdata = 16'h0000;
            end
            default: begin
                w_cs    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered bus outputs, load value, handshake and overrun counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_load    <= 32'd0;
            r_addr    <= 3'd0;
            r_cs      <= 1'b0;
            r_wdata   <= 16'h0000;
            r_running <= 1'b0;
            r_req     <= 1'b0;
            r_ovr     <= '0;
        end else begin
            r_addr    <= w_addr;
            r_cs      <= w_cs;
            r_wdata   <= w_wdata;
            r_running <= (w_next == S_RUN) || (w_next == S_CLR) ||
                         (w_next == S_CLR_GAP);

            if (w_next == S_STOP) begin
                r_load <= w_load;
            end

            if (sample_ack && r_req) begin
                r_req <= 1'b0;
            end

            if (r_state == S_CLR) begin
                if (r_req) begin
                    if (r_ovr != {OVR_W{1'b1}}) begin
                        r_ovr <= r_ovr + 1'b1;
                    end
                end else begin
                    r_req <= 1'b1;
                end
            end

            if ((r_state == S_IDLE) && (w_next == S_STOP)) begin
                r_ovr <= '0;
            end
        end
    end

    assign tmr_address    = r_addr;
    assign tmr_chipselect = r_cs;
    assign tmr_write_n    = ~r_cs;
    assign tmr_writedata  = r_wdata;
    assign sample_req     = r_req;
    assign running        = r_running;
    assign overrun_cnt    = r_ovr;

`ifdef SCHED_LAT_EN
    logic [31:0] r_lat_cnt;
    logic [31:0] r_ack_lat;

    // Counter restarts at the tick being serviced and runs while the request
    // is outstanding; +1 accounts for the ack cycle itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lat_cnt <= 32'd0;
            r_ack_lat <= 32'd0;
        end else begin
            if (r_state == S_CLR) begin
                r_lat_cnt <= 32'd0;
            end else if (r_req) begin
                r_lat_cnt <= r_lat_cnt + 32'd1;
            end
            if (sample_ack && r_req) begin
                r_ack_lat <= r_lat_cnt + 32'd1;
            end
        end
    end

    assign ack_latency = r_ack_lat;
`else
    assign ack_latency = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_timer_sample_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_timer_sample_scheduler
//  Description : Self-checking bench for timer_sample_scheduler with a
//                behavioural model of the interval timer s1 slave.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timer_sample_scheduler;

`ifdef SCHED_LAT_EN
    localparam bit LAT_EN = 1'b1;
`else
    localparam bit LAT_EN = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        enable     = 1'b0;
    logic [31:0] interval   = 32'd0;
    logic        reprogram  = 1'b0;
    logic        sample_ack = 1'b0;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;
    logic        sample_req;
    logic        running;
    logic [7:0]  overrun_cnt;
    logic [31:0] ack_latency;

    timer_sample_scheduler #(
        .DEFAULT_INTERVAL (50000),
        .OVR_W            (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .interval       (interval),
        .reprogram      (reprogram),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_readdata   (tmr_readdata),
        .tmr_irq        (tmr_irq),
        .sample_req     (sample_req),
        .sample_ack     (sample_ack),
        .running        (running),
        .overrun_cnt    (overrun_cnt),
        .ack_latency    (ack_latency)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- interval timer model (s1 slave) ----------------
    logic        t_run, t_to, t_ito, t_cont;
    logic [31:0] t_per, t_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0;
            t_per <= 32'd0; t_cnt <= 32'd0;
        end else begin
            if (t_run) begin
                if (t_cnt == 32'd0) begin
                    t_to  <= 1'b1;
                    t_cnt <= t_per;
                    if (!t_cont) t_run <= 1'b0;
                end else begin
                    t_cnt <= t_cnt - 32'd1;
                end
            end
            if (tmr_chipselect && !tmr_write_n) begin
                case (tmr_address)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        t_ito  <= tmr_writedata[0];
                        t_cont <= tmr_writedata[1];
                        if (tmr_writedata[2]) begin t_run <= 1'b1; t_cnt <= t_per; end
                        if (tmr_writedata[3]) t_run <= 1'b0;
                    end
                    3'd2: t_per[15:0]  <= tmr_writedata;
                    3'd3: t_per[31:16] <= tmr_writedata;
                    default: ;
                endcase
            end
        end
    end
    assign tmr_irq      = t_to & t_ito;
    assign tmr_readdata = 16'h0000;

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [18:0] exp_q[$];
    logic [18:0] obs_q[$];
    int          obs_cyc[$];
    int          exp_req[$];
    int          n_addr0 = 0;

    // Advance one cycle, sample away from the edge, log any bus write.
    task automatic tick();
        @(negedge clk);
        #1;
        if (tmr_chipselect && !tmr_write_n) begin
            obs_q.push_back({tmr_address, tmr_writedata});
            obs_cyc.push_back(cyc);
            if (tmr_address == 3'd0) n_addr0++;
        end
    endtask

    task automatic wait_lvl(input int sel, input logic lvl, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (((sel == 0) ? tmr_irq : sample_req) == lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b0; reprogram = 1'b0; sample_ack = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        exp_q.delete(); obs_q.delete(); obs_cyc.delete(); exp_req.delete();
        n_addr0 = 0;
    endtask

    // Pushes the four programming writes and enables; returns once four
    // writes have been observed (during the CTRL cycle).
    task automatic start_timer(input logic [31:0] iv, input logic [15:0] pl, input logic [15:0] ph);
        exp_q.push_back({3'd1, 16'h0008});
        exp_q.push_back({3'd2, pl});
        exp_q.push_back({3'd3, ph});
        exp_q.push_back({3'd1, 16'h0007});
        interval = iv;
        enable   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (obs_q.size() >= 4) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        total++; if (tmr_address !== 3'd0)    begin bad++; $display("FAIL rst_address got=%0d want=0", tmr_address); end
        total++; if (tmr_chipselect !== 1'b0) begin bad++; $display("FAIL rst_chipselect got=%b want=0", tmr_chipselect); end
        total++; if (tmr_write_n !== 1'b1)    begin bad++; $display("FAIL rst_write_n got=%b want=1", tmr_write_n); end
        total++; if (tmr_writedata !== 16'h0) begin bad++; $display("FAIL rst_writedata got=%h want=0000", tmr_writedata); end
        total++; if (sample_req !== 1'b0)     begin bad++; $display("FAIL rst_sample_req got=%b want=0", sample_req); end
        total++; if (running !== 1'b0)        begin bad++; $display("FAIL rst_running got=%b want=0", running); end
        total++; if (overrun_cnt !== 8'd0)    begin bad++; $display("FAIL rst_overrun got=%0d want=0", overrun_cnt); end
        total++; if (ack_latency !== 32'd0)   begin bad++; $display("FAIL rst_ack_latency got=%0d want=0", ack_latency); end
    endtask

    task automatic test_program();
        logic [18:0] e, o;
        do_reset();
        start_timer(32'd100, 16'h0063, 16'h0000);
        total++;
        if (obs_cyc.size() < 4) begin
            bad++; $display("FAIL prog_count got=%0d want=4", obs_cyc.size());
        end else if (obs_cyc[3] - obs_cyc[0] != 3) begin
            bad++; $display("FAIL prog_consecutive got=%0d want=3", obs_cyc[3] - obs_cyc[0]);
        end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL prog_running_ctrl got=%b want=0", running); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL prog_write got=none want=%0d:%h", e[18:16], e[15:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL prog_write got=%0d:%h want=%0d:%h", o[18:16], o[15:0], e[18:16], e[15:0]); end
            end
        end
        tick();
        total++; if (running !== 1'b1) begin bad++; $display("FAIL prog_running_run got=%b want=1", running); end
    endtask

    task automatic test_default_and_halt();
        logic [18:0] e, o;
        do_reset();
        start_timer(32'd1, 16'hC34F, 16'h0000);
        tick();
        exp_q.push_back({3'd1, 16'h0008});
        enable = 1'b0;
        repeat (4) tick();
        total++; if (obs_q.size() != 5) begin bad++; $display("FAIL dflt_count got=%0d want=5", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL dflt_write got=none want=%0d:%h", e[18:16], e[15:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL dflt_write got=%0d:%h want=%0d:%h", o[18:16], o[15:0], e[18:16], e[15:0]); end
            end
        end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL dflt_running got=%b want=0", running); end
        // interval=2 is the smallest value taken literally (P=1)
        do_reset();
        start_timer(32'd2, 16'h0001, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL iv2_write got=%0d:%h want=%0d:%h", o[18:16], o[15:0], e[18:16], e[15:0]); end
        end
    endtask

    task automatic test_reprogram();
        logic [18:0] e, o;
        do_reset();
        start_timer(32'd100, 16'h0063, 16'h0000);
        repeat (5) tick();
        obs_q.delete(); exp_q.delete();
        exp_q.push_back({3'd1, 16'h0008});
        exp_q.push_back({3'd2, 16'h2344});
        exp_q.push_back({3'd3, 16'h0001});
        exp_q.push_back({3'd1, 16'h0007});
        interval  = 32'h0001_2345;
        reprogram = 1'b1;
        tick();
        reprogram = 1'b0;
        repeat (6) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL reprog_write got=none want=%0d:%h", e[18:16], e[15:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL reprog_write got=%0d:%h want=%0d:%h", o[18:16], o[15:0], e[18:16], e[15:0]); end
            end
        end
        total++; if (running !== 1'b1) begin bad++; $display("FAIL reprog_running got=%b want=1", running); end
    endtask

    task automatic test_ticks();
        bit ok;
        int t_irq, t_prev, er;
        do_reset();
        start_timer(32'd100, 16'h0063, 16'h0000);
        n_addr0 = 0;
        t_prev  = -1;
        for (int k = 0; k < 5; k++) begin
            wait_lvl(0, 1'b1, 150, ok);
            total++; if (!ok) begin bad++; $display("FAIL tick_irq timeout got=none want=irq"); return; end
            t_irq = cyc;
            exp_req.push_back(t_irq + 2);
            if (t_prev >= 0) begin
                total++; if (t_irq - t_prev != 100) begin bad++; $display("FAIL tick_period got=%0d want=100", t_irq - t_prev); end
            end
            t_prev = t_irq;
            wait_lvl(1, 1'b1, 10, ok);
            er = exp_req.pop_front();
            total++; if (!ok || cyc != er) begin bad++; $display("FAIL tick_req_rise got=%0d want=%0d", cyc, er); end
            repeat (4) tick();
            sample_ack = 1'b1;
            tick();
            sample_ack = 1'b0;
            total++; if (sample_req !== 1'b0) begin bad++; $display("FAIL tick_ack_clear got=%b want=0", sample_req); end
            total++; if (ack_latency !== (LAT_EN ? 32'd5 : 32'd0)) begin bad++; $display("FAIL tick_latency got=%0d want=%0d", ack_latency, LAT_EN ? 5 : 0); end
        end
        total++; if (n_addr0 != 5)        begin bad++; $display("FAIL tick_clear_writes got=%0d want=5", n_addr0); end
        total++; if (overrun_cnt !== 8'd0) begin bad++; $display("FAIL tick_overrun got=%0d want=0", overrun_cnt); end
    endtask

    task automatic test_overrun();
        bit ok;
        do_reset();
        start_timer(32'd10, 16'h0009, 16'h0000);
        for (int k = 1; k <= 300; k++) begin
            wait_lvl(0, 1'b1, 30, ok);
            if (!ok) begin total++; bad++; $display("FAIL ovr_irq timeout got=none want=irq k=%0d", k); return; end
            wait_lvl(0, 1'b0, 10, ok);
            if (!ok) begin total++; bad++; $display("FAIL ovr_irq_clear timeout got=high want=low k=%0d", k); return; end
            if (k == 100) begin
                total++; if (overrun_cnt !== 8'd99) begin bad++; $display("FAIL ovr_mid got=%0d want=99", overrun_cnt); end
            end
        end
        total++; if (overrun_cnt !== 8'd255) begin bad++; $display("FAIL ovr_saturate got=%0d want=255", overrun_cnt); end
        total++; if (sample_req !== 1'b1)    begin bad++; $display("FAIL ovr_req_held got=%b want=1", sample_req); end
        enable = 1'b0;
        repeat (6) tick();
        total++; if (running !== 1'b0)       begin bad++; $display("FAIL ovr_halt_running got=%b want=0", running); end
        total++; if (sample_req !== 1'b1)    begin bad++; $display("FAIL ovr_halt_req got=%b want=1", sample_req); end
        total++; if (overrun_cnt !== 8'd255) begin bad++; $display("FAIL ovr_halt_keep got=%0d want=255", overrun_cnt); end
        sample_ack = 1'b1; tick(); sample_ack = 1'b0;
        total++; if (sample_req !== 1'b0)    begin bad++; $display("FAIL ovr_late_ack got=%b want=0", sample_req); end
        sample_ack = 1'b1; tick(); sample_ack = 1'b0; tick();
        total++; if (sample_req !== 1'b0)    begin bad++; $display("FAIL ovr_stray_ack got=%b want=0", sample_req); end
        enable = 1'b1;
        tick();
        total++; if (overrun_cnt !== 8'd0)   begin bad++; $display("FAIL ovr_clear_on_start got=%0d want=0", overrun_cnt); end
    endtask

    task automatic test_abort_pl();
        bit irq_seen, run_seen;
        do_reset();
        interval = 32'd100;
        exp_q.push_back({3'd1, 16'h0008});
        exp_q.push_back({3'd2, 16'h0063});
        exp_q.push_back({3'd1, 16'h0008});
        enable = 1'b1;
        tick();             // STOP cycle
        tick();             // PL cycle
        enable = 1'b0;
        irq_seen = 1'b0;
        run_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (tmr_irq) irq_seen = 1'b1;
            if (running) run_seen = 1'b1;
        end
        total++; if (obs_q.size() != 3) begin bad++; $display("FAIL abort_count got=%0d want=3", obs_q.size()); end
        for (int i = 0; i < 3; i++) begin
            logic [18:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 19'h7FFFF;
            total++;
            if (o !== e) begin bad++; $display("FAIL abort_write got=%0d:%h want=%0d:%h", o[18:16], o[15:0], e[18:16], e[15:0]); end
        end
        total++; if (irq_seen) begin bad++; $display("FAIL abort_irq got=1 want=0"); end
        total++; if (run_seen) begin bad++; $display("FAIL abort_running got=1 want=0"); end
    endtask

    task automatic test_latency();
        bit ok;
        do_reset();
        start_timer(32'd50, 16'h0031, 16'h0000);
        wait_lvl(1, 1'b1, 80, ok);
        total++; if (!ok) begin bad++; $display("FAIL lat_req timeout got=none want=req"); return; end
        repeat (6) tick();
        sample_ack = 1'b1;
        tick();
        sample_ack = 1'b0;
        total++; if (ack_latency !== (LAT_EN ? 32'd7 : 32'd0)) begin bad++; $display("FAIL lat_value got=%0d want=%0d", ack_latency, LAT_EN ? 7 : 0); end
        total++; if (sample_req !== 1'b0) begin bad++; $display("FAIL lat_req_clear got=%b want=0", sample_req); end
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        start_timer(32'd20, 16'h0013, 16'h0000);
        wait_lvl(1, 1'b1, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL arst_req timeout got=none want=req"); return; end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (running !== 1'b0)    begin bad++; $display("FAIL arst_running got=%b want=0", running); end
        total++; if (sample_req !== 1'b0) begin bad++; $display("FAIL arst_req got=%b want=0", sample_req); end
        total++; if (tmr_write_n !== 1'b1) begin bad++; $display("FAIL arst_write_n got=%b want=1", tmr_write_n); end
    endtask

    initial begin
        test_reset();
        test_program();
        test_default_and_halt();
        test_reprogram();
        test_ticks();
        test_overrun();
        test_abort_pl();
        test_latency();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
